// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler.
// Register map of i2c_top, control/status constants, FSM state encoding,
// bus payload struct and a small helper to size requester indices.
package i2c_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned DEV_W  = 7;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned TCNT_W = 16;

   localparam logic [ADDR_W-1:0] REG_BITRATE = 32'h0000_001C;
   localparam logic [ADDR_W-1:0] REG_ADDR    = 32'h0000_001D;
   localparam logic [ADDR_W-1:0] REG_DATA    = 32'h0000_001E;
   localparam logic [ADDR_W-1:0] REG_CTRL    = 32'h0000_001F;

   localparam logic [DATA_W-1:0] CTRL_START = 32'h0000_0050;
   localparam int unsigned       STAT_BUSY  = 0;

   localparam logic [STRB_W-1:0] STRB_WR = 4'hF;
   localparam logic [STRB_W-1:0] STRB_RD = 4'h0;

   typedef enum logic [2:0] {
      ST_CFG  = 3'd0,
      ST_IDLE = 3'd1,
      ST_ADDR = 3'd2,
      ST_WDAT = 3'd3,
      ST_CTRL = 3'd4,
      ST_POLL = 3'd5,
      ST_RDAT = 3'd6,
      ST_DONE = 3'd7
   } state_t;

   // One register-bus access as presented to i2c_top
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_req_t;

   // Width of a requester index (at least one bit)
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Address register payload: 7-bit slave address followed by the R/W bit
   function automatic logic [DATA_W-1:0] addr_word(input logic [DEV_W-1:0] dev,
                                                   input logic rw);
      return DATA_W'({dev, rw});
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr.
// Ports:
//   req     - request levels, one per requester
//   ptr     - index searched first
//   grant_c - one-hot grant (combinational)
//   any_c   - at least one request is asserted (combinational)
module i2c_rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant_c,
   output logic             any_c
);

   int unsigned idx;

   // Scan requesters starting at ptr, wrapping modulo N_REQ
   always_comb begin
      grant_c = '0;
      any_c   = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr) + k) % N_REQ;
         if (!any_c && req[IDX_W'(idx)]) begin
            grant_c[IDX_W'(idx)] = 1'b1;
            any_c                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Arbitrates N_REQ requesters issuing single-byte I2C transactions and runs
// the i2c_top register bus on behalf of the granted requester.
// Optional feature macro: I2C_TIMEOUT_EN (poll timeout with err reporting).
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   req, req_dev, req_rw, req_wdata - per-requester request level and payload
//   ack, rdata, err               - one-cycle done pulse, read byte, timeout flag
//   mem_valid/addr/wdata/wstrb    - register bus request to i2c_top
//   mem_rdata, mem_ready          - register bus response from i2c_top
module i2c_txn_scheduler
   import i2c_pkg::*;
#(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned BITRATE     = 500000,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [DEV_W*N_REQ-1:0]  req_dev,
   input  logic [N_REQ-1:0]        req_rw,
   input  logic [BYTE_W*N_REQ-1:0] req_wdata,
   output logic [N_REQ-1:0]        ack,
   output logic [BYTE_W-1:0]       rdata,
   output logic                    err,
   output logic                    mem_valid,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic [STRB_W-1:0]       mem_wstrb,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ready
);

   localparam int unsigned IDX_W = idx_width(N_REQ);

   state_t              state;
   logic                bitrate_done;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    lat_idx;
   logic [N_REQ-1:0]    lat_gnt;
   logic [DEV_W-1:0]    lat_dev;
   logic                lat_rw;
   logic [BYTE_W-1:0]   lat_wdata;
   logic [BYTE_W-1:0]   rd_byte;

   logic [N_REQ-1:0]    grant_c;
   logic                grant_any_c;
   logic [IDX_W-1:0]    grant_idx_c;
   bus_req_t            bus_c;
   logic                bus_state_c;
   logic                unused_c;

`ifdef I2C_TIMEOUT_EN
   logic [TCNT_W-1:0]   tcnt;
   logic                tmo;
   logic                timed_out_c;

   assign timed_out_c = (tcnt >= TCNT_W'(TIMEOUT_CYC));
`else
   assign err = 1'b0;
`endif

   // Upper read-data bits carry nothing this block needs
   assign unused_c = ^{mem_rdata[DATA_W-1:BYTE_W], 32'(TIMEOUT_CYC)};

   i2c_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (req),
      .ptr     (rr_ptr),
      .grant_c (grant_c),
      .any_c   (grant_any_c)
   );

   // One-hot grant to index
   always_comb begin
      grant_idx_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_c[i]) grant_idx_c = IDX_W'(i);
      end
   end

   // Bus access owned by each state
   always_comb begin
      bus_c       = '0;
      bus_state_c = 1'b1;
      case (state)
         ST_CFG:  bus_c = '{addr: REG_BITRATE, wdata: DATA_W'(BITRATE), wstrb: STRB_WR};
         ST_ADDR: bus_c = '{addr: REG_ADDR, wdata: addr_word(lat_dev, lat_rw), wstrb: STRB_WR};
         ST_WDAT: bus_c = '{addr: REG_DATA, wdata: DATA_W'(lat_wdata), wstrb: STRB_WR};
         ST_CTRL: bus_c = '{addr: REG_CTRL, wdata: CTRL_START, wstrb: STRB_WR};
         ST_POLL: bus_c = '{addr: REG_CTRL, wdata: '0, wstrb: STRB_RD};
         ST_RDAT: bus_c = '{addr: REG_DATA, wdata: '0, wstrb: STRB_RD};
         default: bus_state_c = 1'b0;
      endcase
   end

   // Transaction sequencer; a new access is only issued while mem_valid is low,
   // which yields the idle cycle after every completed access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_CFG;
         bitrate_done <= 1'b0;
         rr_ptr       <= '0;
         lat_idx      <= '0;
         lat_gnt      <= '0;
         lat_dev      <= '0;
         lat_rw       <= 1'b0;
         lat_wdata    <= '0;
         rd_byte      <= '0;
         ack          <= '0;
         rdata        <= '0;
         mem_valid    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wstrb    <= '0;
`ifdef I2C_TIMEOUT_EN
         tmo          <= 1'b0;
         err          <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef I2C_TIMEOUT_EN
         err <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (bitrate_done && grant_any_c) begin
                  lat_gnt   <= grant_c;
                  lat_idx   <= grant_idx_c;
                  lat_dev   <= req_dev[32'(grant_idx_c)*DEV_W +: DEV_W];
                  lat_rw    <= req_rw[grant_idx_c];
                  lat_wdata <= req_wdata[32'(grant_idx_c)*BYTE_W +: BYTE_W];
                  rd_byte   <= '0;
`ifdef I2C_TIMEOUT_EN
                  tmo       <= 1'b0;
`endif
                  state     <= ST_ADDR;
               end
            end
            ST_DONE: begin
               ack    <= lat_gnt;
               rdata  <= lat_rw ? rd_byte : '0;
`ifdef I2C_TIMEOUT_EN
               err    <= tmo;
`endif
               rr_ptr <= (32'(lat_idx) == N_REQ - 1) ? '0 : lat_idx + 1'b1;
               state  <= ST_IDLE;
            end
            default: begin
               if (bus_state_c) begin
                  if (!mem_valid) begin
`ifdef I2C_TIMEOUT_EN
                     if (state == ST_POLL && timed_out_c) begin
                        tmo   <= 1'b1;
                        state <= ST_DONE;
                     end else
`endif
                     begin
                        mem_valid <= 1'b1;
                        mem_addr  <= bus_c.addr;
                        mem_wdata <= bus_c.wdata;
                        mem_wstrb <= bus_c.wstrb;
                     end
                  end else if (mem_ready) begin
                     mem_valid <= 1'b0;
                     mem_wstrb <= '0;
                     case (state)
                        ST_CFG: begin
                           bitrate_done <= 1'b1;
                           state        <= ST_IDLE;
                        end
                        ST_ADDR: state <= lat_rw ? ST_CTRL : ST_WDAT;
                        ST_WDAT: state <= ST_CTRL;
                        ST_CTRL: state <= ST_POLL;
                        ST_POLL: begin
                           if (!mem_rdata[STAT_BUSY]) state <= lat_rw ? ST_RDAT : ST_DONE;
                        end
                        ST_RDAT: begin
                           rd_byte <= mem_rdata[BYTE_W-1:0];
                           state   <= ST_DONE;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

`ifdef I2C_TIMEOUT_EN
   // Poll budget: cleared in CTRL, counts every POLL cycle, saturates at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (state == ST_CTRL) begin
         tcnt <= '0;
      end else if (state == ST_POLL && !timed_out_c) begin
         tcnt <= tcnt + 1'b1;
      end
   end
`endif

endmodule
